// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_addsub
//  Description : Pipelined carry-lookahead adder/subtractor. The operands are
//                cut into GROUP-bit lookahead slices; each pipeline stage
//                resolves one slice and hands a registered carry to the next.
//                A valid/ready handshake on both sides, with one global
//                advance enable, streams one operation per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c0,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int c_nstg = WIDTH / GROUP;
    localparam int c_last = c_nstg - 1;

    // Reject geometries that do not tile the operand into whole slices.
    generate
        if ((GROUP < 1) || (GROUP > 8) || ((WIDTH % GROUP) != 0)) begin : g_bad_params
            $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP and GROUP must be 1..8");
        end
    endgenerate

    // Pipeline registers feeding slice k. r_s[k] holds the sum bits already
    // resolved by the slices below k; r_a/r_b carry the still-unused operand
    // bits forward so each slice sees its operands together with its carry.
    logic [c_nstg-1:0][WIDTH-1:0] r_a;
    logic [c_nstg-1:0][WIDTH-1:0] r_b;
    logic [c_nstg-1:0][WIDTH-1:0] r_s;
    logic [c_nstg-1:0]            r_c;
    logic [c_nstg-1:0]            r_v;

    // Output register
    logic [WIDTH-1:0] r_s_out;
    logic             r_c_out;
    logic             r_ovf;
    logic             r_zero;
    logic             r_out_v;

    // Per-slice combinational results
    logic [c_nstg-1:0][WIDTH-1:0] w_s_next;
    logic [c_nstg-1:0]            w_cout;
    logic [c_nstg-1:0]            w_cmsb;
    logic                         w_en;

    // Whole pipe advances together; it only freezes when a result is waiting
    // and the consumer is not taking it.
    assign w_en     = !r_out_v || out_ready;
    assign in_ready = w_en;

    generate
        for (genvar k = 0; k < c_nstg; k++) begin : g_slice
            logic [GROUP-1:0] w_a;
            logic [GROUP-1:0] w_b;
            logic [GROUP-1:0] w_g;
            logic [GROUP-1:0] w_p;
            logic [GROUP:0]   w_cc;
            logic [GROUP-1:0] w_sum;
            logic [WIDTH-1:0] w_merge;

            assign w_a = r_a[k][k*GROUP +: GROUP];
            assign w_b = r_b[k][k*GROUP +: GROUP];
            assign w_g = w_a & w_b;
            assign w_p = w_a | w_b;

            // Fully expanded lookahead: every carry is a flat sum of products
            // of generate/propagate terms and the registered slice carry-in.
            always_comb begin : b_lookahead
                logic w_acc;
                logic w_term;
                w_acc   = 1'b0;
                w_term  = 1'b0;
                w_cc    = '0;
                w_cc[0] = r_c[k];
                for (int i = 0; i < GROUP; i++) begin
                    w_acc = r_c[k];
                    for (int j = 0; j <= i; j++) begin
                        w_acc = w_acc & w_p[j];
                    end
                    for (int j = 0; j <= i; j++) begin
                        w_term = w_g[j];
                        for (int m = j + 1; m <= i; m++) begin
                            w_term = w_term & w_p[m];
                        end
                        w_acc = w_acc | w_term;
                    end
                    w_cc[i+1] = w_acc;
                end
            end

            assign w_sum = w_a ^ w_b ^ w_cc[GROUP-1:0];

            // Drop this slice's sum into the partial result travelling with it.
            always_comb begin
                w_merge = r_s[k];
                w_merge[k*GROUP +: GROUP] = w_sum;
            end

            assign w_s_next[k] = w_merge;
            assign w_cout[k]   = w_cc[GROUP];
            assign w_cmsb[k]   = w_cc[GROUP-1];
        end
    endgenerate

    // Shift operands, partial sums, carries and valid bits one stage per
    // enabled clock; reset empties the pipe and clears the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v     <= '0;
            r_out_v <= 1'b0;
            r_s_out <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_en) begin
            r_v[0] <= in_valid;
            r_a[0] <= A;
            r_b[0] <= sub ? ~B : B;
            r_c[0] <= sub | c0;
            r_s[0] <= '0;
            for (int k = 1; k < c_nstg; k++) begin
                r_v[k] <= r_v[k-1];
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
                r_s[k] <= w_s_next[k-1];
                r_c[k] <= w_cout[k-1];
            end
            r_out_v <= r_v[c_last];
            r_s_out <= w_s_next[c_last];
            r_c_out <= w_cout[c_last];
            r_ovf   <= w_cmsb[c_last] ^ w_cout[c_last];
            r_zero  <= ~|w_s_next[c_last];
        end
    end

    // Operand bits below the last slice and inner-slice MSB carries of the
    // lower slices are never consumed.
    logic w_unused;
    assign w_unused = ^{r_a[c_last], r_b[c_last], w_cmsb};

    assign out_valid = r_out_v;
    assign S         = r_s_out;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_addsub
//  Description : Scoreboard bench for cla_pipe_addsub (WIDTH=16, GROUP=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        c0;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        c_out;
    logic        ovf;
    logic        zero;

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(16), .GROUP(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .c0       (c0),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (S),
        .c_out    (c_out),
        .ovf      (ovf),
        .zero     (zero)
    );

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic [31:0] t;
    } exp_t;

    exp_t   q[$];
    exp_t   drv_exp;
    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    logic   chk_lat  = 1'b0;

    // Edge counter
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Capture: push the expected response whenever an operand set transfers.
    initial begin : p_capture
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                e   = drv_exp;
                e.t = cyc + 1;
                q.push_back(e);
            end
        end
    end

    // Monitor: pop and compare whenever a result is handed over.
    initial begin : p_monitor
        exp_t        e;
        logic        prev_stall;
        logic [19:0] prev_out;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                checks++;
                if (in_ready !== (!out_valid || out_ready)) begin
                    failures++;
                    $display("FAIL in_ready: got %b, want %b (out_valid=%b out_ready=%b)",
                             in_ready, !out_valid || out_ready, out_valid, out_ready);
                end
                if (prev_stall) begin
                    checks++;
                    if ({out_valid, S, c_out, ovf, zero} !== prev_out) begin
                        failures++;
                        $display("FAIL stall_hold: got %h, want %h", {out_valid, S, c_out, ovf, zero}, prev_out);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output: got S=%h with no pending operation, want none", S);
                    end else begin
                        e = q.pop_front();
                        if (S !== e.s || c_out !== e.c || ovf !== e.v || zero !== e.z) begin
                            failures++;
                            $display("FAIL result: got S=%h c=%b v=%b z=%b, want S=%h c=%b v=%b z=%b",
                                     S, c_out, ovf, zero, e.s, e.c, e.v, e.z);
                        end
                        if (chk_lat) begin
                            checks++;
                            if (cyc - int'(e.t) != 4) begin
                                failures++;
                                $display("FAIL latency: got %0d edges, want 4", cyc - int'(e.t));
                            end
                        end
                    end
                end
            end
            prev_stall = (rst === 1'b0) && out_valid && !out_ready;
            prev_out   = {out_valid, S, c_out, ovf, zero};
        end
    end

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input logic s);
        logic [15:0] bb;
        logic        ci;
        logic [16:0] r;
        logic [15:0] lo;
        exp_t        e;
        bb  = s ? ~b : b;
        ci  = s ? 1'b1 : c;
        r   = {1'b0, a} + {1'b0, bb} + {16'd0, ci};
        lo  = {1'b0, a[14:0]} + {1'b0, bb[14:0]} + {15'd0, ci};
        e.s = r[15:0];
        e.c = r[16];
        e.v = lo[15] ^ r[16];
        e.z = (r[15:0] == 16'd0);
        e.t = '0;
        return e;
    endfunction

    // Present one operand set and hold it until it is accepted.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic s, input exp_t e);
        logic acc;
        int   n;
        A        = a;
        B        = b;
        c0       = c;
        sub      = s;
        drv_exp  = e;
        in_valid = 1'b1;
        n        = 0;
        acc      = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 50) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, want acceptance", n);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic hand(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                        input logic [15:0] es, input logic ec, input logic ev, input logic ez);
        exp_t e;
        e.s = es; e.c = ec; e.v = ev; e.z = ez; e.t = '0;
        issue(a, b, c, s, e);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d results outstanding, want 0", q.size());
        end
        idle(2);
    endtask

    logic [15:0] st_a [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'hA5A5, 16'h7FFF, 16'h0001, 16'hC350};
    logic [15:0] st_b [8] = '{16'h4321, 16'h0001, 16'h8000, 16'hF0F0, 16'h5A5A, 16'hFFFF, 16'h0002, 16'h3CB0};
    logic        st_c [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        st_s [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        c0        = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        drv_exp   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b, want 0", out_valid); end
        checks++; if (S !== 16'h0000)     begin failures++; $display("FAIL rst_S: got %h, want 0000", S); end
        checks++; if (c_out !== 1'b0)     begin failures++; $display("FAIL rst_c_out: got %b, want 0", c_out); end
        checks++; if (ovf !== 1'b0)       begin failures++; $display("FAIL rst_ovf: got %b, want 0", ovf); end
        checks++; if (zero !== 1'b0)      begin failures++; $display("FAIL rst_zero: got %b, want 0", zero); end
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL rst_in_ready: got %b, want 1", in_ready); end
        @(posedge clk);
        #1;

        // Directed vectors, back to back, latency checked
        chk_lat = 1'b1;
        hand(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        hand(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        hand(16'h0FFF, 16'h0000, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        hand(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        hand(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        hand(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        hand(16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        hand(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0);
        drain();

        // Bubble pattern 1,0,1,0,0,1
        hand(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0);
        idle(1);
        hand(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        idle(2);
        hand(16'hF000, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        drain();

        // Streaming with stall on cycles 6..8
        chk_lat = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    issue(st_a[i], st_b[i], st_c[i], st_s[i], model(st_a[i], st_b[i], st_c[i], st_s[i]));
                end
            end
            begin
                repeat (5) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-flight; rst also overrides a simultaneous transfer
        chk_lat = 1'b1;
        hand(16'h1111, 16'h1111, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0);
        hand(16'h2222, 16'h2222, 1'b0, 1'b0, 16'h4444, 1'b0, 1'b0, 1'b0);
        hand(16'h3333, 16'h3333, 1'b0, 1'b0, 16'h6666, 1'b0, 1'b0, 1'b0);
        A = 16'h4444; B = 16'h4444; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_valid: got %b at cycle %0d, want 0", out_valid, i);
            end
        end
        @(posedge clk);
        #1;
        hand(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, want $finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
